// File: rtl/elbeth_lsu.sv
// ELBETH load/store unit: turns one byte-addressed load/store into a single
// word-addressed transaction on the data port of elbeth_memory.
module elbeth_lsu #(
   parameter int ADDR_WIDTH     = 10,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lsu_req,
   input  logic                  lsu_we,
   input  logic [1:0]            lsu_size,
   input  logic                  lsu_unsigned,
   input  logic [ADDR_WIDTH-1:0] lsu_addr,
   input  logic [31:0]           lsu_wdata,
   output logic [31:0]           lsu_rdata,
   output logic                  lsu_valid,
   output logic                  lsu_busy,
   output logic                  lsu_fault,
   output logic [1:0]            lsu_fault_code,
   output logic                  mem_enable,
   output logic [ADDR_WIDTH-3:0] mem_addr,
   output logic [31:0]           mem_data_in,
   output logic [3:0]            mem_wr,
   input  logic [31:0]           mem_data_out,
   input  logic                  mem_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_MISALIGN = 2'b01;
   localparam logic [1:0] FC_SIZE     = 2'b10;
   localparam logic [1:0] FC_TIMEOUT  = 2'b11;
   localparam logic [7:0] CNT_LAST    = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q;
   logic [1:0]  chk_code;
   logic        timeout;
   logic        req_we;
   logic [1:0]  req_size;
   logic [1:0]  req_lo;
   logic        req_unsigned;

   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'b00:   lane_mask = 4'b0001 << a;
         2'b01:   lane_mask = a[1] ? 4'b1100 : 4'b0011;
         2'b10:   lane_mask = 4'b1111;
         default: lane_mask = 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [1:0] a,
                                             input logic [31:0] wd);
      case (size)
         2'b00:   lane_data = {24'd0, wd[7:0]} << {a, 3'b000};
         2'b01:   lane_data = a[1] ? {wd[15:0], 16'd0} : {16'd0, wd[15:0]};
         2'b10:   lane_data = wd;
         default: lane_data = 32'd0;
      endcase
   endfunction

   // Move the addressed lane(s) down to bit 0, then sign- or zero-extend.
   function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] a,
                                                input logic uns, input logic [31:0] d);
      logic [31:0] sh;
      sh = 32'd0;
      case (size)
         2'b00: begin
            sh = d >> {a, 3'b000};
            load_extract = {{24{~uns & sh[7]}}, sh[7:0]};
         end
         2'b01: begin
            sh = a[1] ? (d >> 16) : d;
            load_extract = {{16{~uns & sh[15]}}, sh[15:0]};
         end
         default: load_extract = d;
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      chk_code = FC_NONE;
      if (lsu_size == 2'b11)
         chk_code = FC_SIZE;
      else if ((lsu_size == 2'b01 && lsu_addr[0]) ||
               (lsu_size == 2'b10 && lsu_addr[1:0] != 2'b00))
         chk_code = FC_MISALIGN;
      timeout = (cnt_q == CNT_LAST) && !mem_ready;
      case (state_q)
         IDLE:    if (lsu_req) state_d = (chk_code != FC_NONE) ? RESP : ACCESS;
         ACCESS:  if (mem_ready || timeout) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   assign lsu_busy = (state_q != IDLE);

   // Request fields needed after acceptance for lane extraction.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && lsu_req) begin
         req_we       <= lsu_we;
         req_size     <= lsu_size;
         req_lo       <= lsu_addr[1:0];
         req_unsigned <= lsu_unsigned;
      end
   end

   // Response fields are one-cycle pulses; memory drive is held through ACCESS.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lsu_rdata      <= 32'd0;
         lsu_valid      <= 1'b0;
         lsu_fault      <= 1'b0;
         lsu_fault_code <= FC_NONE;
         mem_enable     <= 1'b0;
         mem_addr       <= '0;
         mem_data_in    <= 32'd0;
         mem_wr         <= 4'b0000;
         cnt_q          <= 8'd0;
      end else begin
         lsu_rdata      <= 32'd0;
         lsu_valid      <= 1'b0;
         lsu_fault      <= 1'b0;
         lsu_fault_code <= FC_NONE;
         case (state_q)
            IDLE: begin
               if (lsu_req) begin
                  if (chk_code != FC_NONE) begin
                     lsu_valid      <= 1'b1;
                     lsu_fault      <= 1'b1;
                     lsu_fault_code <= chk_code;
                  end else begin
                     mem_enable  <= 1'b1;
                     mem_addr    <= lsu_addr[ADDR_WIDTH-1:2];
                     mem_wr      <= lsu_we ? lane_mask(lsu_size, lsu_addr[1:0]) : 4'b0000;
                     mem_data_in <= lsu_we ? lane_data(lsu_size, lsu_addr[1:0], lsu_wdata) : 32'd0;
                     cnt_q       <= 8'd0;
                  end
               end
            end
            ACCESS: begin
               if (mem_ready || timeout) begin
                  mem_enable  <= 1'b0;
                  mem_wr      <= 4'b0000;
                  mem_data_in <= 32'd0;
                  lsu_valid   <= 1'b1;
                  if (mem_ready) begin
                     lsu_rdata <= req_we ? 32'd0
                                         : load_extract(req_size, req_lo, req_unsigned, mem_data_out);
                  end else begin
                     lsu_fault      <= 1'b1;
                     lsu_fault_code <= FC_TIMEOUT;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_elbeth_lsu.sv
// Directed bench for elbeth_lsu with a small word memory that can stall
// its ready response.
module tb_elbeth_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        lsu_req;
   logic        lsu_we;
   logic [1:0]  lsu_size;
   logic        lsu_unsigned;
   logic [9:0]  lsu_addr;
   logic [31:0] lsu_wdata;
   logic [31:0] lsu_rdata;
   logic        lsu_valid;
   logic        lsu_busy;
   logic        lsu_fault;
   logic [1:0]  lsu_fault_code;
   logic        mem_enable;
   logic [7:0]  mem_addr;
   logic [31:0] mem_data_in;
   logic [3:0]  mem_wr;
   logic [31:0] mem_data_out;
   logic        mem_ready;

   int n_tests = 0;
   int n_fail  = 0;

   elbeth_lsu #(.ADDR_WIDTH(10), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size),
      .lsu_unsigned(lsu_unsigned), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_rdata(lsu_rdata), .lsu_valid(lsu_valid), .lsu_busy(lsu_busy),
      .lsu_fault(lsu_fault), .lsu_fault_code(lsu_fault_code),
      .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_wr(mem_wr), .mem_data_out(mem_data_out), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   // Memory model: ready after ready_delay stalled cycles, or never.
   logic [31:0] mem [0:255];
   int ready_delay = 0;
   bit ready_never = 1'b0;
   int wait_cnt    = 0;

   assign mem_ready    = !ready_never && (wait_cnt >= ready_delay);
   assign mem_data_out = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_enable && !mem_ready) wait_cnt <= wait_cnt + 1;
      else                          wait_cnt <= 0;
      if (mem_enable && mem_ready)
         for (int i = 0; i < 4; i++)
            if (mem_wr[i]) mem[mem_addr][8*i +: 8] <= mem_data_in[8*i +: 8];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Results of the last transaction.
   int          r_lat;
   logic [31:0] r_rd;
   logic        r_flt;
   logic [1:0]  r_code;
   logic        r_en0;
   logic        r_en_any;
   logic [3:0]  r_wr0;
   logic [31:0] r_din0;
   logic [7:0]  r_addr0;

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (lsu_busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (lsu_busy) check("idle_timeout", 32'(lsu_busy), 32'd0);
   endtask

   // Latency counts edges after the accepting edge until lsu_valid is seen.
   task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [9:0] addr, input logic [31:0] wd);
      wait_idle();
      lsu_we = we; lsu_size = sz; lsu_unsigned = uns; lsu_addr = addr; lsu_wdata = wd;
      lsu_req = 1'b1;
      @(posedge clk); #1;
      lsu_req  = 1'b0;
      r_en0    = mem_enable;
      r_en_any = mem_enable;
      r_wr0    = mem_wr;
      r_din0   = mem_data_in;
      r_addr0  = mem_addr;
      r_lat    = 0;
      while (!lsu_valid && r_lat < 300) begin
         @(posedge clk); #1;
         r_lat++;
         r_en_any = r_en_any | mem_enable;
      end
      r_rd   = lsu_rdata;
      r_flt  = lsu_fault;
      r_code = lsu_fault_code;
   endtask

   initial begin
      rst = 1'b0;
      lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = 2'b00; lsu_unsigned = 1'b0;
      lsu_addr = 10'd0; lsu_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(lsu_valid), 32'd0);
      check("rst_busy", 32'(lsu_busy), 32'd0);
      check("rst_enable", 32'(mem_enable), 32'd0);
      check("rst_wr", 32'(mem_wr), 32'd0);
      check("rst_rdata", lsu_rdata, 32'd0);
      check("rst_code", 32'(lsu_fault_code), 32'd0);
      @(negedge clk) rst = 1'b1;

      // Byte store, lane 1
      xact(1'b1, 2'b00, 1'b0, 10'h001, 32'h0000_00A5);
      check("bst_en", 32'(r_en0), 32'd1);
      check("bst_addr", 32'(r_addr0), 32'd0);
      check("bst_wr", 32'(r_wr0), 32'b0010);
      check("bst_din", r_din0, 32'h0000_A500);
      check("bst_lat", 32'(r_lat), 32'd1);
      check("bst_rdata", r_rd, 32'd0);
      check("bst_fault", 32'(r_flt), 32'd0);
      @(posedge clk); #1;
      check("bst_pulse", 32'(lsu_valid), 32'd0);

      // Word store then word load
      xact(1'b1, 2'b10, 1'b0, 10'h008, 32'hDEAD_BEEF);
      check("wst_wr", 32'(r_wr0), 32'b1111);
      check("wst_addr", 32'(r_addr0), 32'd2);
      xact(1'b0, 2'b10, 1'b0, 10'h008, 32'hFFFF_FFFF);
      check("wld_wr", 32'(r_wr0), 32'b0000);
      check("wld_din", r_din0, 32'd0);
      check("wld_rdata", r_rd, 32'hDEAD_BEEF);

      // Sub-word loads from word 1
      xact(1'b1, 2'b10, 1'b0, 10'h004, 32'h8001_1234);
      xact(1'b0, 2'b01, 1'b0, 10'h006, 32'd0);
      check("hld_s", r_rd, 32'hFFFF_8001);
      xact(1'b0, 2'b01, 1'b1, 10'h006, 32'd0);
      check("hld_u", r_rd, 32'h0000_8001);
      xact(1'b0, 2'b00, 1'b0, 10'h004, 32'd0);
      check("bld_s4", r_rd, 32'h0000_0034);
      xact(1'b0, 2'b00, 1'b0, 10'h007, 32'd0);
      check("bld_s7", r_rd, 32'hFFFF_FF80);
      xact(1'b0, 2'b01, 1'b0, 10'h004, 32'd0);
      check("hld_lo", r_rd, 32'h0000_1234);

      // Check-time faults
      xact(1'b0, 2'b10, 1'b0, 10'h002, 32'd0);
      check("mis_lat", 32'(r_lat), 32'd0);
      check("mis_fault", 32'(r_flt), 32'd1);
      check("mis_code", 32'(r_code), 32'b01);
      check("mis_en", 32'(r_en_any), 32'd0);
      xact(1'b1, 2'b11, 1'b0, 10'h000, 32'd0);
      check("ill_lat", 32'(r_lat), 32'd0);
      check("ill_code", 32'(r_code), 32'b10);
      check("ill_en", 32'(r_en_any), 32'd0);
      check("ill_rdata", r_rd, 32'd0);

      // Timeout
      ready_never = 1'b1;
      xact(1'b0, 2'b10, 1'b0, 10'h008, 32'd0);
      check("to_lat", 32'(r_lat), 32'd16);
      check("to_fault", 32'(r_flt), 32'd1);
      check("to_code", 32'(r_code), 32'b11);
      check("to_en", 32'(mem_enable), 32'd0);
      ready_never = 1'b0;

      // Ready delayed 3 cycles
      ready_delay = 3;
      xact(1'b0, 2'b10, 1'b0, 10'h008, 32'd0);
      check("dly_lat", 32'(r_lat), 32'd4);
      check("dly_fault", 32'(r_flt), 32'd0);
      check("dly_rdata", r_rd, 32'hDEAD_BEEF);
      ready_delay = 0;

      // Asynchronous reset during ACCESS
      ready_never = 1'b1;
      wait_idle();
      lsu_we = 1'b0; lsu_size = 2'b10; lsu_addr = 10'h008; lsu_req = 1'b1;
      @(posedge clk); #1;
      lsu_req = 1'b0;
      check("ar_en_before", 32'(mem_enable), 32'd1);
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      check("ar_en", 32'(mem_enable), 32'd0);
      check("ar_busy", 32'(lsu_busy), 32'd0);
      check("ar_valid", 32'(lsu_valid), 32'd0);
      check("ar_wr", 32'(mem_wr), 32'd0);
      @(negedge clk) rst = 1'b1;
      ready_never = 1'b0;
      xact(1'b0, 2'b10, 1'b0, 10'h008, 32'd0);
      check("ar_after_lat", 32'(r_lat), 32'd1);
      check("ar_after_rd", r_rd, 32'hDEAD_BEEF);

      // Request while busy is dropped
      xact(1'b1, 2'b10, 1'b0, 10'h00C, 32'd0);
      ready_delay = 2;
      wait_idle();
      lsu_we = 1'b0; lsu_size = 2'b10; lsu_addr = 10'h004; lsu_req = 1'b1;
      @(posedge clk); #1;
      lsu_req = 1'b0;
      @(negedge clk);
      check("bz_busy", 32'(lsu_busy), 32'd1);
      lsu_we = 1'b1; lsu_addr = 10'h00C; lsu_wdata = 32'h1234_5678; lsu_req = 1'b1;
      @(negedge clk);
      lsu_req = 1'b0; lsu_we = 1'b0;
      begin
         int n;
         n = 0;
         while (!lsu_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
      end
      check("bz_valid", 32'(lsu_valid), 32'd1);
      check("bz_rdata", lsu_rdata, 32'h8001_1234);
      ready_delay = 0;
      xact(1'b0, 2'b10, 1'b0, 10'h00C, 32'd0);
      check("bz_dropped", r_rd, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
